// File: rtl/mode_dispatch_fsm_pkg.sv
// Shared definitions for the matrix calculator control path.
// Holds the controller state codes, the mode-select switch codes and the
// state width. The dispatch FSM, datapath muxing and the status display all
// import this package, so the state codes below are the ones seen on the
// seven-segment display.
package mode_fsm_pkg;

    localparam int STATE_W = 4;
    localparam int MODE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE            = 4'd0,
        S_INPUT_DIM       = 4'd1,
        S_INPUT_DATA      = 4'd2,
        S_GEN_RANDOM      = 4'd3,
        S_BONUS_RUN       = 4'd4,
        S_DISPLAY_WAIT    = 4'd5,
        S_DISPLAY_PRINT   = 4'd6,
        S_CALC_SELECT_OP  = 4'd7,
        S_CALC_SELECT_MAT = 4'd8,
        S_CALC_CHECK      = 4'd9,
        S_CALC_EXEC       = 4'd10,
        S_CALC_DONE       = 4'd11,
        S_CALC_ERROR      = 4'd12
    } state_e;

    localparam logic [MODE_W-1:0] MODE_INPUT   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_RANDOM  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_DISPLAY = 3'd2;
    localparam logic [MODE_W-1:0] MODE_CALC    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BONUS   = 3'd4;

    // First state of the flow selected by a legal mode code.
    function automatic state_e mode_target(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_INPUT:   return S_INPUT_DIM;
            MODE_RANDOM:  return S_GEN_RANDOM;
            MODE_DISPLAY: return S_DISPLAY_WAIT;
            MODE_CALC:    return S_CALC_SELECT_OP;
            MODE_BONUS:   return S_BONUS_RUN;
            default:      return S_IDLE;
        endcase
    endfunction

    // States that wait on a sub-module; user-wait states are never timed out.
    function automatic logic wdog_watched(input state_e s);
        case (s)
            S_IDLE, S_CALC_SELECT_OP, S_CALC_SELECT_MAT,
            S_DISPLAY_WAIT, S_CALC_ERROR: return 1'b0;
            default:                      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mode_dispatch_fsm_if.sv
// Control bundle between the dispatch FSM and the rest of the calculator.
//   master : switch/button/sub-module side (drives sw, buttons, sub_done, chk_*)
//   slave  : the dispatch FSM (drives state, enter, sec_left, illegal_mode, aborted)
interface mode_dispatch_fsm_if #(
    parameter int SW_W = 3
);
    logic [SW_W-1:0]                  sw;
    logic                             btn_c;
    logic                             btn_esc;
    logic                             sub_done;
    logic                             chk_ok;
    logic                             chk_bad;
    logic [mode_fsm_pkg::STATE_W-1:0] state;
    logic                             enter;
    logic [3:0]                       sec_left;
    logic                             illegal_mode;
    logic                             aborted;

    modport master (
        output sw, btn_c, btn_esc, sub_done, chk_ok, chk_bad,
        input  state, enter, sec_left, illegal_mode, aborted
    );

    modport slave (
        input  sw, btn_c, btn_esc, sub_done, chk_ok, chk_bad,
        output state, enter, sec_left, illegal_mode, aborted
    );
endinterface

// File: rtl/mode_dispatch_fsm_countdown.sv
// sec_countdown: one-second prescaler plus 4-bit seconds down-counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load count with load_val and clear the prescaler
//   load_val   : seconds to load (0 stops the counter)
//   tick       : prescaler wrap while the counter is non-zero
//   count      : seconds remaining
//   expire     : final second in progress (count == 1); tick && expire is the
//                edge on which the counter reaches zero
module sec_countdown #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       tick,
    output logic [3:0] count,
    output logic       expire
);
    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    count_q, count_d;

    // tick/expire ignore load so the FSM next-state logic, which drives load,
    // never sees a combinational path back through this block.
    assign tick   = (count_q != 4'd0) && (presc_q == PRESC_MAX);
    assign expire = (count_q == 4'd1);
    assign count  = count_q;

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (load) begin
            presc_d = '0;
            count_d = load_val;
        end else if (count_q != 4'd0) begin
            if (tick) begin
                presc_d = '0;
                count_d = count_q - 4'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mode_dispatch_fsm.sv
// mode_dispatch_fsm: top-level control FSM of the matrix calculator.
// Decodes the mode switches in IDLE, sequences the input / random / bonus /
// display / calculate flows, runs the error countdown, limits dimension-check
// retries and honours a global escape.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mode_dispatch_fsm_if.slave (sw, btn_c, btn_esc, sub_done,
//                chk_ok, chk_bad in; state, enter, sec_left, illegal_mode,
//                aborted out)
// Build option MODE_FSM_WDOG_EN adds a per-state watchdog of WDOG_CYC cycles
// on the sub-module-driven states.
//
// state             | meaning
// IDLE              | waiting for btn_c with a mode code on sw
// INPUT_DIM/DATA    | matrix entry: dimensions, then data
// GEN_RANDOM        | random matrix generation
// BONUS_RUN         | bonus feature running
// DISPLAY_WAIT/PRINT| choose matrix, then print it
// CALC_SELECT_OP    | user picks operation (btn_c confirms)
// CALC_SELECT_MAT   | user picks operands
// CALC_CHECK        | dimension check result pending
// CALC_EXEC/DONE    | operation running / result shown
// CALC_ERROR        | bad dimensions, countdown before reselect
module mode_dispatch_fsm
    import mode_fsm_pkg::*;
#(
    parameter int SW_W      = 3,
    parameter int CLK_HZ    = 100_000_000,
    parameter int ERR_SEC   = 5,
    parameter int MAX_RETRY = 3,
    parameter int WDOG_CYC  = 2**28
) (
    input logic                 clk,
    input logic                 rst_n,
    mode_dispatch_fsm_if.slave  bus
);
    if (ERR_SEC < 1 || ERR_SEC > 15) begin : g_bad_err_sec
        $error("ERR_SEC out of range 1..15");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_max_retry
        $error("MAX_RETRY out of range 1..7");
    end
    if (CLK_HZ < 1 || WDOG_CYC < 1) begin : g_bad_cycles
        $error("CLK_HZ and WDOG_CYC must be positive");
    end

    state_e      state_q, state_d;
    logic        enter_q, enter_d;
    logic        illegal_q, illegal_d;
    logic        aborted_q, aborted_d;
    logic [2:0]  retry_q, retry_d;
    logic        abort_set;
    logic        wdog_fire;

    logic [SW_W-1:0] sw_l;
    logic [31:0]     sw_ext;
    logic            mode_legal;

    logic        cd_load;
    logic [3:0]  cd_load_val;
    logic        cd_tick;
    logic [3:0]  cd_count;
    logic        cd_expire;

    assign sw_l       = bus.sw;
    assign sw_ext     = 32'(sw_l);
    // Comparing the zero-extended code also rejects any set upper bit.
    assign mode_legal = (sw_ext <= 32'(MODE_BONUS));

    sec_countdown #(.CLK_HZ(CLK_HZ)) u_countdown (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cd_load),
        .load_val (cd_load_val),
        .tick     (cd_tick),
        .count    (cd_count),
        .expire   (cd_expire)
    );

`ifdef MODE_FSM_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_q, wdog_d;

    // Fires on the cycle the count would reach WDOG_CYC, so a hung state is
    // left after exactly WDOG_CYC cycles.
    assign wdog_fire = wdog_watched(state_q) && (wdog_q == WW'(WDOG_CYC - 1));

    always_comb begin
        wdog_d = wdog_q + 1'b1;
        if (state_d != state_q || !wdog_watched(state_q)) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            enter_q   <= 1'b0;
            illegal_q <= 1'b0;
            aborted_q <= 1'b0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            enter_q   <= enter_d;
            illegal_q <= illegal_d;
            aborted_q <= aborted_d;
            retry_q   <= retry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        abort_set = 1'b0;
        if (bus.btn_esc && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            abort_set = 1'b1;
        end else if (wdog_fire) begin
            state_d   = S_IDLE;
            abort_set = 1'b1;
        end else begin
            case (state_q)
                S_IDLE:
                    if (bus.btn_c && mode_legal) state_d = mode_target(sw_ext[MODE_W-1:0]);
                S_INPUT_DIM:
                    if (bus.sub_done) state_d = S_INPUT_DATA;
                S_DISPLAY_WAIT:
                    if (bus.sub_done) state_d = S_DISPLAY_PRINT;
                S_INPUT_DATA, S_GEN_RANDOM, S_BONUS_RUN, S_DISPLAY_PRINT, S_CALC_DONE:
                    if (bus.sub_done) state_d = S_IDLE;
                S_CALC_SELECT_OP:
                    if (bus.btn_c) state_d = S_CALC_SELECT_MAT;
                S_CALC_SELECT_MAT:
                    if (bus.sub_done) state_d = S_CALC_CHECK;
                S_CALC_CHECK: begin
                    if (bus.chk_ok) begin
                        state_d = S_CALC_EXEC;
                    end else if (bus.chk_bad) begin
                        retry_d = retry_q + 3'd1;
                        if (retry_d == 3'(MAX_RETRY)) begin
                            state_d   = S_IDLE;
                            abort_set = 1'b1;
                        end else begin
                            state_d = S_CALC_ERROR;
                        end
                    end
                end
                S_CALC_EXEC:
                    if (bus.sub_done) state_d = S_CALC_DONE;
                S_CALC_ERROR: begin
                    if (bus.btn_c) begin
                        state_d = S_CALC_CHECK;
                    end else if (cd_tick && cd_expire) begin
                        state_d = S_CALC_SELECT_MAT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d == S_CALC_SELECT_OP && state_q != S_CALC_SELECT_OP) begin
            retry_d = '0;
        end
    end

    always_comb begin
        cd_load     = 1'b0;
        cd_load_val = 4'd0;
        // Load on entry; reload with zero on any exit so sec_left reads 0
        // outside CALC_ERROR.
        if (state_d == S_CALC_ERROR && state_q != S_CALC_ERROR) begin
            cd_load     = 1'b1;
            cd_load_val = 4'(ERR_SEC);
        end else if (state_q == S_CALC_ERROR && state_d != S_CALC_ERROR) begin
            cd_load     = 1'b1;
        end

        enter_d   = (state_d != state_q);
        illegal_d = (state_q == S_IDLE) && bus.btn_c && !mode_legal;
        aborted_d = aborted_q;
        if (state_q == S_IDLE && bus.btn_c) aborted_d = 1'b0;
        if (abort_set)                       aborted_d = 1'b1;
    end

    assign bus.state        = state_q;
    assign bus.enter        = enter_q;
    assign bus.sec_left     = cd_count;
    assign bus.illegal_mode = illegal_q;
    assign bus.aborted      = aborted_q;
endmodule

// File: tb/tb_mode_dispatch_fsm.sv
// Directed bench for mode_dispatch_fsm with a cycle-indexed scoreboard:
// stimulus pushes expected output values tagged with the cycle they must
// appear in; an independent monitor pops and compares on the falling edge.
module tb_mode_dispatch_fsm;
    localparam int F_STATE = 0;
    localparam int F_ENTER = 1;
    localparam int F_SEC   = 2;
    localparam int F_ILL   = 3;
    localparam int F_ABT   = 4;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string nm;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    sb_t  sb_q[$];
    sb_t  e_mon;
    int   act_mon;

    mode_dispatch_fsm_if #(.SW_W(3)) bus ();

    mode_dispatch_fsm #(
        .SW_W      (3),
        .CLK_HZ    (10),
        .ERR_SEC   (3),
        .MAX_RETRY (2),
        .WDOG_CYC  (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dut_field(input int f);
        case (f)
            F_STATE: return int'(bus.state);
            F_ENTER: return int'(bus.enter);
            F_SEC:   return int'(bus.sec_left);
            F_ILL:   return int'(bus.illegal_mode);
            default: return int'(bus.aborted);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e_mon   = sb_q.pop_front();
            act_mon = dut_field(e_mon.fld);
            n_checks++;
            if (e_mon.cyc != cyc || act_mon != e_mon.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d, due %0d)",
                         e_mon.nm, act_mon, e_mon.val, cyc, e_mon.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int f, input int v, input string nm);
        sb_t e;
        e.cyc = cyc + dc;
        e.fld = f;
        e.val = v;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    task automatic press_c();
        bus.btn_c = 1'b1;
        step();
        bus.btn_c = 1'b0;
    endtask

    task automatic press_esc();
        bus.btn_esc = 1'b1;
        step();
        bus.btn_esc = 1'b0;
    endtask

    task automatic press_sub();
        bus.sub_done = 1'b1;
        step();
        bus.sub_done = 1'b0;
    endtask

    task automatic press_bad();
        bus.chk_bad = 1'b1;
        step();
        bus.chk_bad = 1'b0;
    endtask

    task automatic enter_calc_error();
        bus.sw = 3'd3;
        press_c();
        expect_at(0, F_STATE, 7, "calc_sel_op");
        expect_at(0, F_ABT, 0, "calc_abort_clr");
        press_c();
        expect_at(0, F_STATE, 8, "calc_sel_mat");
        press_sub();
        expect_at(0, F_STATE, 9, "calc_check");
        press_bad();
        expect_at(0, F_STATE, 12, "err_entry_state");
        expect_at(0, F_SEC, 3, "err_entry_sec");
        expect_at(0, F_ENTER, 1, "err_entry_enter");
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got no end of stimulus, expected end before 200000 ns");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.sw       = '0;
        bus.btn_c    = 1'b0;
        bus.btn_esc  = 1'b0;
        bus.sub_done = 1'b0;
        bus.chk_ok   = 1'b0;
        bus.chk_bad  = 1'b0;
        repeat (3) step();
        expect_at(0, F_STATE, 0, "rst_state");
        expect_at(0, F_ENTER, 0, "rst_enter");
        expect_at(0, F_SEC, 0, "rst_sec");
        expect_at(0, F_ILL, 0, "rst_illegal");
        expect_at(0, F_ABT, 0, "rst_aborted");
        rst_n = 1'b1;
        step();
        expect_at(0, F_ENTER, 0, "no_enter_after_rst");

        // Calc dispatch, enter pulse width, escape from a user-wait state.
        bus.sw = 3'd3;
        press_c();
        expect_at(0, F_STATE, 7, "disp_calc_state");
        expect_at(0, F_ENTER, 1, "disp_calc_enter");
        step();
        expect_at(0, F_ENTER, 0, "enter_one_cycle");
        expect_at(0, F_STATE, 7, "sel_op_holds");
        press_esc();
        expect_at(0, F_STATE, 0, "esc_sel_op_state");
        expect_at(0, F_ABT, 1, "esc_sel_op_abort");

        // Illegal codes: stay in IDLE, single pulse, btn_c still clears aborted.
        bus.sw = 3'd6;
        press_c();
        expect_at(0, F_STATE, 0, "ill6_state");
        expect_at(0, F_ILL, 1, "ill6_pulse");
        expect_at(0, F_ABT, 0, "ill6_abort_clr");
        expect_at(0, F_ENTER, 0, "ill6_no_enter");
        step();
        expect_at(0, F_ILL, 0, "ill6_one_cycle");
        bus.sw = 3'd5;
        press_c();
        expect_at(0, F_ILL, 1, "ill5_pulse");
        expect_at(0, F_STATE, 0, "ill5_state");
        bus.btn_esc = 1'b1;
        bus.sub_done = 1'b1;
        step();
        bus.btn_esc = 1'b0;
        bus.sub_done = 1'b0;
        expect_at(0, F_STATE, 0, "idle_ignores_esc_sub");
        expect_at(0, F_ABT, 0, "idle_esc_no_abort");

        // Input flow.
        bus.sw = 3'd0;
        press_c();
        expect_at(0, F_STATE, 1, "input_dim");
        press_sub();
        expect_at(0, F_STATE, 2, "input_data");
        press_sub();
        expect_at(0, F_STATE, 0, "input_done");

        // Display flow; btn_c in DISPLAY_WAIT has no effect.
        bus.sw = 3'd2;
        press_c();
        expect_at(0, F_STATE, 5, "disp_wait");
        press_c();
        expect_at(0, F_STATE, 5, "disp_wait_holds");
        press_sub();
        expect_at(0, F_STATE, 6, "disp_print");
        press_sub();
        expect_at(0, F_STATE, 0, "disp_done");

        // Bonus flow; chk_ok outside CALC_CHECK is ignored.
        bus.sw = 3'd4;
        press_c();
        expect_at(0, F_STATE, 4, "bonus");
        bus.chk_ok = 1'b1;
        step();
        bus.chk_ok = 1'b0;
        expect_at(0, F_STATE, 4, "bonus_ignores_chk");
        press_sub();
        expect_at(0, F_STATE, 0, "bonus_done");

        // Random flow with no sub_done: watchdog or indefinite hold.
        bus.sw = 3'd1;
        press_c();
        expect_at(0, F_STATE, 3, "gen_random");
`ifdef MODE_FSM_WDOG_EN
        expect_at(19, F_STATE, 3, "wdog_not_yet");
        expect_at(20, F_STATE, 0, "wdog_state");
        expect_at(20, F_ABT, 1, "wdog_abort");
        repeat (20) step();
`else
        repeat (105) step();
        expect_at(0, F_STATE, 3, "no_wdog_hold");
        press_sub();
        expect_at(0, F_STATE, 0, "gen_random_done");
`endif

        // Full countdown to expiry (retry count becomes 1).
        enter_calc_error();
        expect_at(9, F_SEC, 3, "cd_3_last");
        expect_at(10, F_SEC, 2, "cd_2_first");
        expect_at(19, F_SEC, 2, "cd_2_last");
        expect_at(20, F_SEC, 1, "cd_1_first");
        expect_at(29, F_STATE, 12, "cd_still_err");
        expect_at(29, F_SEC, 1, "cd_1_last");
        expect_at(30, F_STATE, 8, "cd_expire_state");
        expect_at(30, F_SEC, 0, "cd_expire_sec");
        expect_at(30, F_ENTER, 1, "cd_expire_enter");
        repeat (30) step();

        // Second bad check in the same calculation exhausts retries.
        press_sub();
        expect_at(0, F_STATE, 9, "retry_check");
        press_bad();
        expect_at(0, F_STATE, 0, "exhaust_state");
        expect_at(0, F_ABT, 1, "exhaust_abort");
        expect_at(0, F_SEC, 0, "exhaust_sec");

        // Early retry, chk_ok priority, escape from CALC_EXEC.
        enter_calc_error();
        repeat (14) step();
        expect_at(0, F_SEC, 2, "early_sec_before");
        press_c();
        expect_at(0, F_STATE, 9, "early_retry_state");
        expect_at(0, F_SEC, 0, "early_retry_sec");
        bus.chk_ok  = 1'b1;
        bus.chk_bad = 1'b1;
        step();
        bus.chk_ok  = 1'b0;
        bus.chk_bad = 1'b0;
        expect_at(0, F_STATE, 10, "chk_ok_priority");
        press_esc();
        expect_at(0, F_STATE, 0, "esc_exec_state");
        expect_at(0, F_ABT, 1, "esc_exec_abort");

        // Synchronous reset in the middle of a countdown.
        enter_calc_error();
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        expect_at(0, F_STATE, 0, "mid_rst_state");
        expect_at(0, F_SEC, 0, "mid_rst_sec");
        expect_at(0, F_ENTER, 0, "mid_rst_enter");
        expect_at(0, F_ILL, 0, "mid_rst_illegal");
        expect_at(0, F_ABT, 0, "mid_rst_abort");
        step();
        expect_at(0, F_ENTER, 0, "mid_rst_no_enter");
        expect_at(0, F_STATE, 0, "mid_rst_idle");
        expect_at(0, F_SEC, 0, "mid_rst_sec_hold");

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) step();
        step();
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
